// File: rtl/systolic_array_4x4_pkg.sv
// Shared constants for the 4x4 output-stationary systolic matrix multiplier.
// Optional build macro: SYSTOLIC_SAT_EN (saturating accumulation).
package systolic_array_4x4_pkg;

    localparam int ARRAY_DIM      = 4;
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_FRAC_WIDTH = 8;
    localparam int DONE_CYCLE     = 3 * ARRAY_DIM - 2;
    localparam int CNT_WIDTH      = $clog2(DONE_CYCLE + 1);

endpackage

// File: rtl/systolic_array_4x4_pe.sv
// One fixed-point MAC cell: accumulates a*b and forwards a east, b south.
// With SYSTOLIC_SAT_EN defined the scaled product and the accumulator saturate instead of wrapping.
module systolic_pe
    import systolic_array_4x4_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] acc_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          term;
    logic [WIDTH-1:0]          acc_d;
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH-1:0]          b_q;
    logic [WIDTH-1:0]          acc_q;

    assign prod = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [2*WIDTH-1:0] P_MAX   = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] P_MIN   = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]          ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]          ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod_sh;
    logic [WIDTH:0]            sum;

    // One guard bit on the sum exposes signed overflow as a mismatch of the top two bits.
    always_comb begin
        prod_sh = prod >>> FRAC_WIDTH;
        if (prod_sh > P_MAX) begin
            term = ACC_MAX;
        end else if (prod_sh < P_MIN) begin
            term = ACC_MIN;
        end else begin
            term = prod_sh[WIDTH-1:0];
        end
        sum = {acc_q[WIDTH-1], acc_q} + {term[WIDTH-1], term};
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            acc_d = sum[WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_d = sum[WIDTH-1:0];
        end
    end
`else
    assign term  = WIDTH'(prod >>> FRAC_WIDTH);
    assign acc_d = acc_q + term;
`endif

    // NOTE: reset is tested first so it wins over the enable in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary systolic array; inputs arrive pre-skewed, done is sticky until reset.
// Optional build macro: SYSTOLIC_SAT_EN (saturating accumulation inside each PE).
module systolic_array_4x4
    import systolic_array_4x4_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     in_north0,
    input  logic [WIDTH-1:0]                     in_north1,
    input  logic [WIDTH-1:0]                     in_north2,
    input  logic [WIDTH-1:0]                     in_north3,
    input  logic [WIDTH-1:0]                     in_west0,
    input  logic [WIDTH-1:0]                     in_west4,
    input  logic [WIDTH-1:0]                     in_west8,
    input  logic [WIDTH-1:0]                     in_west12,
    output logic                                 done,
    output logic [ARRAY_DIM*ARRAY_DIM*WIDTH-1:0] out
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic [WIDTH-1:0] west_in  [ARRAY_DIM];
    logic [WIDTH-1:0] north_in [ARRAY_DIM];
    logic [WIDTH-1:0] a_e      [ARRAY_DIM][ARRAY_DIM];
    logic [WIDTH-1:0] b_s      [ARRAY_DIM][ARRAY_DIM];
    logic [WIDTH-1:0] acc      [ARRAY_DIM][ARRAY_DIM];

    assign west_in[0]  = in_west0;
    assign west_in[1]  = in_west4;
    assign west_in[2]  = in_west8;
    assign west_in[3]  = in_west12;
    assign north_in[0] = in_north0;
    assign north_in[1] = in_north1;
    assign north_in[2] = in_north2;
    assign north_in[3] = in_north3;

    // The last operand pair reaches PE(3,3) on cycle 9, so the count of 10 marks completion.
    assign done  = (cnt_q == CNT_WIDTH'(DONE_CYCLE));
    assign cnt_d = done ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_row
        for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_col
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;

            if (j == 0) begin : g_a_edge
                assign a_in = west_in[i];
            end else begin : g_a_int
                assign a_in = a_e[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = north_in[j];
            end else begin : g_b_int
                assign b_in = b_s[i-1][j];
            end

            systolic_pe #(
                .WIDTH      (WIDTH),
                .FRAC_WIDTH (FRAC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en_i  (!done),
                .a_i   (a_in),
                .b_i   (b_in),
                .a_o   (a_e[i][j]),
                .b_o   (b_s[i][j]),
                .acc_o (acc[i][j])
            );

            assign out[(ARRAY_DIM*i+j)*WIDTH +: WIDTH] = acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Scoreboard bench for systolic_array_4x4: stimulus pushes hand-computed C matrices, a monitor checks them when done rises.
module tb_systolic_array_4x4;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_north0 = '0, in_north1 = '0, in_north2 = '0, in_north3 = '0;
    logic [W-1:0]  in_west0 = '0, in_west4 = '0, in_west8 = '0, in_west12 = '0;
    logic          done;
    logic [16*W-1:0] out;

    systolic_array_4x4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_north0 (in_north0),
        .in_north1 (in_north1),
        .in_north2 (in_north2),
        .in_north3 (in_north3),
        .in_west0  (in_west0),
        .in_west4  (in_west4),
        .in_west8  (in_west8),
        .in_west12 (in_west12),
        .done      (done),
        .out       (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [16*W-1:0] c;
    } exp_t;

    exp_t     sb[$];
    int       total = 0;
    int       bad   = 0;
    int       cyc;
    logic     done_prev = 1'b0;
    logic [W-1:0] am [4][4];
    logic [W-1:0] bm [4][4];

    int A1[4][4] = '{'{2, 1, 2, 1}, '{0, 1, 0, 1}, '{1, 2, 0, 1}, '{1, 1, 1, 0}};
    int B1[4][4] = '{'{0, 1, 4, 3}, '{3, 0, 1, 0}, '{1, 4, 1, 2}, '{3, 0, 2, 0}};
    int C1[4][4] = '{'{8, 10, 13, 10}, '{6, 0, 3, 0}, '{9, 1, 8, 3}, '{4, 5, 6, 5}};
    int AN[4][4] = '{'{-1, 0, 0, 0}, '{0, -1, 0, 0}, '{0, 0, -1, 0}, '{0, 0, 0, -1}};
    int CN[4][4] = '{'{0, -1, -4, -3}, '{-3, 0, -1, 0}, '{-1, -4, -1, -2}, '{-3, 0, -2, 0}};
    int A127[4][4] = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}, '{127, 127, 127, 127}, '{127, 127, 127, 127}};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16*W-1:0] pack(input int m[4][4]);
        logic [16*W-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[(4*i+j)*W +: W] = W'(m[i][j] * 256);
        return r;
    endfunction

    function automatic logic [16*W-1:0] fill(input logic [W-1:0] v);
        return {16{v}};
    endfunction

    task automatic load_int(input int a[4][4], input int b[4][4]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = W'(a[i][j] * 256);
                bm[i][j] = W'(b[i][j] * 256);
            end
    endtask

    task automatic load_const(input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = av;
                bm[i][j] = bv;
            end
    endtask

    task automatic set_inputs(input logic [W-1:0] w[4], input logic [W-1:0] n[4]);
        in_west0  = w[0];
        in_west4  = w[1];
        in_west8  = w[2];
        in_west12 = w[3];
        in_north0 = n[0];
        in_north1 = n[1];
        in_north2 = n[2];
        in_north3 = n[3];
    endtask

    // Skewed feed for cycle t, k in reverse order; zeros outside each row/column window.
    task automatic drive(input int t);
        logic [W-1:0] w[4];
        logic [W-1:0] n[4];
        for (int r = 0; r < 4; r++) begin
            int d;
            d = t - r;
            w[r] = '0;
            n[r] = '0;
            if (d >= 0 && d < 4) begin
                w[r] = am[r][3-d];
                n[r] = bm[3-d][r];
            end
        end
        set_inputs(w, n);
    endtask

    task automatic drive_const(input logic [W-1:0] v);
        logic [W-1:0] c[4];
        for (int r = 0; r < 4; r++) c[r] = v;
        set_inputs(c, c);
    endtask

    // Entered and left at a negedge; the next posedge after return is cycle 0.
    task automatic apply_reset();
        rst = 1'b1;
        drive_const('0);
        repeat (2) @(negedge clk);
        check("reset_done_low", {31'b0, done}, 32'd0);
        check("reset_out_zero", {31'b0, (out == '0)}, 32'd1);
        rst = 1'b0;
    endtask

    task automatic run_mat(input string nm, input logic [16*W-1:0] c);
        exp_t e;
        e.name = nm;
        e.c    = c;
        sb.push_back(e);
        apply_reset();
        for (int t = 0; t < 14; t++) begin
            check($sformatf("%s_done_t%0d", nm, t), {31'b0, done}, (t >= 10) ? 32'd1 : 32'd0);
            drive(t);
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: compares the DUT result against the oldest expectation when done rises.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_done_cycle", e.name), cyc, 32'd10);
                for (int p = 0; p < 16; p++)
                    check($sformatf("%s_C%0d%0d", e.name, p / 4, p % 4),
                          {16'b0, out[p*W +: W]}, {16'b0, e.c[p*W +: W]});
            end
        end
        done_prev = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        load_int(A1, B1);
        run_mat("mm", pack(C1));

        // Inputs after done must not disturb the frozen result.
        for (int h = 0; h < 5; h++) begin
            drive_const(16'h1234 + W'(h));
            @(negedge clk);
            check($sformatf("hold_done_%0d", h), {31'b0, done}, 32'd1);
            check($sformatf("hold_out_%0d", h), {31'b0, (out == pack(C1))}, 32'd1);
        end

        load_const(16'h0080, 16'h0080);
        run_mat("frac", fill(16'h0100));

        load_int(AN, B1);
        run_mat("signed", pack(CN));

        load_int(A127, A127);
`ifdef SYSTOLIC_SAT_EN
        run_mat("ovf", fill(16'h7FFF));
`else
        run_mat("ovf", fill(16'h0400));
`endif

        // Abort a run at cycle 5, then repeat the integer matmul from scratch.
        load_int(A1, B1);
        rst = 1'b1;
        drive_const('0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            drive(t);
            @(negedge clk);
        end
        check("midrun_done_low", {31'b0, done}, 32'd0);
        run_mat("mm_rerun", pack(C1));

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
